noc_local_ingress: RTL and testbench
====================================

// Module: noc_local_ingress
// PURPOSE
//  Router-side receiver for the local IP port. Accepts Valid/Data/Last/Ready flits from an IP
//  traffic generator into a flit FIFO and XY-routes each packet from its head-flit destination.
//  Requests one router output, waits for the grant, then streams the packet out intact.
//  Sits between a local IP and the router switch allocator/crossbar.
// PARAMETERS
//  X_CUR       2   X coordinate of this router (7-bit field)
//  Y_CUR       2   Y coordinate of this router (7-bit field)
//  FIFO_DEPTH  8   flit FIFO entries; power of two, >=4
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high reset
//  Valid_IP     in   1            IP flit valid
//  Data_IP      in   DATA_WIDTH   IP flit; [DW-1-:7]=X_DES, [DW-8-:7]=Y_DES, [DW-15-:7]=X_SRC, [DW-22-:7]=Y_SRC
//  Last_IP      in   1            final flit of packet
//  Ready_IP     out  1            ingress can accept a flit
//  route_req    out  5            one-hot request {LOCAL,S,N,W,E}
//  route_grant  in   1            allocator grant for the current route_req
//  Valid_out    out  1            flit to crossbar valid
//  Data_out     out  DATA_WIDTH   flit to crossbar
//  Last_out     out  1            final flit to crossbar
//  Ready_out    in   1            crossbar/downstream ready
//  rx_pkt_cnt   out  10           packets fully accepted from IP
//  tx_pkt_cnt   out  10           packets fully forwarded
//  loopback_flag out 1            sticky: a packet addressed to this router was seen
// BEHAVIOUR
//  Reset: Ready_IP=0 in the reset cycle, then !full; route_req=0, Valid_out=0, Last_out=0,
//   Data_out=0, both counters=0, loopback_flag=0, FIFO empty, FSM=IDLE.
//  Ingress handshake: flit pushed when Valid_IP&&Ready_IP. Ready_IP = !full, combinational from the
//   registered count. When full, no push occurs even if a pop happens in the same cycle.
//  FIFO entry = {Last, Data}. Simultaneous push+pop when not full leaves count unchanged.
//   Pointers wrap at FIFO_DEPTH.
//  rx_pkt_cnt +1 on each pushed flit with Last_IP=1.
//  FSM:
//   IDLE: if FIFO not empty, decode the head flit at the FIFO front, register the one-hot route, -> REQ.
//   REQ: route_req=route. On route_grant -> XFER. route_req stays asserted through XFER.
//   XFER: Valid_out = !empty; Data_out/Last_out = FIFO front (show-ahead). Pop on Valid_out&&Ready_out.
//    On a popped flit with Last=1: route_req=0, tx_pkt_cnt +1, -> IDLE.
//    Latency: first flit visible one cycle after the grant.
//  XY route (unsigned 7-bit compares):
//   X_DES>X_CUR -> E; X_DES<X_CUR -> W;
//   else Y_DES>Y_CUR -> N; Y_DES<Y_CUR -> S;
//   else LOCAL, and set loopback_flag.
//  Boundaries:
//   - FIFO empty mid-packet in XFER: Valid_out=0, hold XFER and route_req, no bubble data.
//   - Ready_out low: hold Data_out/Last_out stable.
//   - Single-flit packet (Last on the head flit): REQ -> XFER -> IDLE after one handshake.
//   - Next packet's head may already sit behind the current tail; IDLE re-decodes it the cycle
//     after the tail pops.
//   - route_grant outside REQ is ignored.
//   - Counters wrap 1023 -> 0.
//   - reset mid-packet: FIFO flushed, partial packet discarded, FSM=IDLE, counters cleared.
// STRUCTURE
//  noc_pkg: DATA_WIDTH import (globe_def), header field offsets/width localparams,
//   port_e {E,W,N,S,LOCAL} and function xy_route(xd,yd,xc,yc) returning one-hot 5 bits.
//  Sub-module flit_fifo #(WIDTH=DATA_WIDTH+1, DEPTH): sync, show-ahead, full/empty/count.
//  Top: routing FSM + counters.
// TESTING
//  1 4-flit packet, X_DES=3,Y_DES=2 at (2,2) -> route_req=00001 (E); after grant, 4 flits out
//    in order, Last on the 4th; rx=tx=1.
//  2 Dest (1,2) -> W; (2,3) -> N; (2,1) -> S; (2,2) -> LOCAL, loopback_flag=1.
//  3 Ready_out=0 with DEPTH=8, IP streams 10 flits -> Ready_IP falls after 8 pushes, no loss;
//    release Ready_out -> all 10 delivered in order.
//  4 Two back-to-back packets E then N with no gap -> second route_req asserted only after the
//    first tail pops; tx_pkt_cnt=2.
//  5 Grant withheld 20 cycles -> Valid_out stays 0, route_req held; grant -> data flows.
//  6 reset asserted after 2 of 4 flits forwarded -> all outputs at reset values next cycle;
//    a new packet then routes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types, header field layout and the XY routing function for the NoC local ingress.
package noc_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned COORD_W    = 7;
  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned PKT_CNT_W  = 10;

  // Header field MSB positions within the head flit.
  localparam int unsigned XD_MSB = DATA_WIDTH - 1;
  localparam int unsigned YD_MSB = DATA_WIDTH - 8;
  localparam int unsigned XS_MSB = DATA_WIDTH - 15;
  localparam int unsigned YS_MSB = DATA_WIDTH - 22;

  typedef enum logic [2:0] {
    P_E     = 3'd0,
    P_W     = 3'd1,
    P_N     = 3'd2,
    P_S     = 3'd3,
    P_LOCAL = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } ing_state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } flit_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [NUM_PORTS-1:0] xy_route(
    input logic [COORD_W-1:0] xd,
    input logic [COORD_W-1:0] yd,
    input logic [COORD_W-1:0] xc,
    input logic [COORD_W-1:0] yc
  );
    logic [NUM_PORTS-1:0] r;
    r = '0;
    if (xd > xc)      r[P_E]     = 1'b1;
    else if (xd < xc) r[P_W]     = 1'b1;
    else if (yd > yc) r[P_N]     = 1'b1;
    else if (yd < yc) r[P_S]     = 1'b1;
    else              r[P_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/noc_local_ingress_fifo.sv
// Synchronous show-ahead flit FIFO with occupancy count; pushes are refused while full.
module flit_fifo
  import noc_pkg::*;
#(
  parameter  int unsigned WIDTH = 33,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/noc_local_ingress.sv
// Local-port ingress: buffers IP flits, XY-routes each packet from its head flit,
// requests one output, and streams the packet to the crossbar once granted.
module noc_local_ingress
  import noc_pkg::*;
#(
  parameter logic [COORD_W-1:0] X_CUR      = 7'd2,
  parameter logic [COORD_W-1:0] Y_CUR      = 7'd2,
  parameter int unsigned        FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Valid_IP,
  input  logic [DATA_WIDTH-1:0] Data_IP,
  input  logic                  Last_IP,
  output logic                  Ready_IP,
  output logic [NUM_PORTS-1:0]  route_req,
  input  logic                  route_grant,
  output logic                  Valid_out,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Last_out,
  input  logic                  Ready_out,
  output logic [PKT_CNT_W-1:0]  rx_pkt_cnt,
  output logic [PKT_CNT_W-1:0]  tx_pkt_cnt,
  output logic                  loopback_flag
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  ing_state_e           r_state;
  ing_state_e           w_state_nxt;
  logic [NUM_PORTS-1:0] r_route;
  logic [NUM_PORTS-1:0] w_route_dec;
  logic                 w_route_load;
  logic [PKT_CNT_W-1:0] r_rx_cnt;
  logic [PKT_CNT_W-1:0] r_tx_cnt;
  logic                 r_loopback;
  flit_t                w_front;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_valid;
  logic                 w_tail_pop;

  flit_fifo #(
    .WIDTH ($bits(flit_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push && !w_full),
    .i_wdata ({Last_IP, Data_IP}),
    .i_pop   (w_pop),
    .o_rdata (w_front),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign Ready_IP = !reset && (w_count != CNT_W'(FIFO_DEPTH));
  assign w_push   = Valid_IP && Ready_IP;

  assign w_route_dec = xy_route(w_front.data[XD_MSB -: COORD_W],
                                w_front.data[YD_MSB -: COORD_W],
                                X_CUR, Y_CUR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_route    <= '0;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_loopback <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_route_load) begin
        r_route <= w_route_dec;
        if (w_route_dec[P_LOCAL]) r_loopback <= 1'b1;
      end
      if (w_push && Last_IP) r_rx_cnt <= r_rx_cnt + PKT_CNT_W'(1);
      if (w_tail_pop)        r_tx_cnt <= r_tx_cnt + PKT_CNT_W'(1);
    end
  end

  // Grant is only honoured in REQ; the route stays latched until the tail leaves.
  always_comb begin
    w_state_nxt  = r_state;
    w_route_load = 1'b0;
    w_valid      = 1'b0;
    w_pop        = 1'b0;
    w_tail_pop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_route_load = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (route_grant) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        w_valid = !w_empty;
        w_pop   = w_valid && Ready_out;
        if (w_pop && w_front.last) begin
          w_tail_pop  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign route_req     = ((r_state == ST_REQ) || (r_state == ST_XFER)) ? r_route : '0;
  assign Valid_out     = w_valid;
  assign Data_out      = w_valid ? w_front.data : '0;
  assign Last_out      = w_valid && w_front.last;
  assign rx_pkt_cnt    = r_rx_cnt;
  assign tx_pkt_cnt    = r_tx_cnt;
  assign loopback_flag = r_loopback;

endmodule

// File: tb/tb_noc_local_ingress.sv
// Scoreboard bench for noc_local_ingress at router (2,2) with an 8-entry FIFO.
module tb_noc_local_ingress;
  import noc_pkg::*;

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Valid_IP = 1'b0;
  logic [DW-1:0] Data_IP = '0;
  logic          Last_IP = 1'b0;
  logic          Ready_IP;
  logic [4:0]    route_req;
  logic          route_grant = 1'b0;
  logic          Valid_out;
  logic [DW-1:0] Data_out;
  logic          Last_out;
  logic          Ready_out = 1'b0;
  logic [9:0]    rx_pkt_cnt;
  logic [9:0]    tx_pkt_cnt;
  logic          loopback_flag;

  noc_local_ingress #(.X_CUR(7'd2), .Y_CUR(7'd2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .Valid_IP(Valid_IP), .Data_IP(Data_IP), .Last_IP(Last_IP), .Ready_IP(Ready_IP),
    .route_req(route_req), .route_grant(route_grant),
    .Valid_out(Valid_out), .Data_out(Data_out), .Last_out(Last_out), .Ready_out(Ready_out),
    .rx_pkt_cnt(rx_pkt_cnt), .tx_pkt_cnt(tx_pkt_cnt), .loopback_flag(loopback_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [4:0]    route;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         occ = 0;
  int         flits_in = 0;
  int         flits_out = 0;
  logic [9:0] m_rx = '0;
  logic [9:0] m_tx = '0;
  logic       m_lb = 1'b0;
  bit         m_head = 1'b1;
  logic [4:0] m_route = '0;
  bit         granted = 1'b0;
  bit         waiting = 1'b0;
  int         wait_cnt = 0;
  int         grant_fixed = -1;
  int         grant_max = 3;
  int         rdy_mode = 2;
  bit         post_rst = 1'b0;
  bit         prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic       prev_last = 1'b0;
  bit         t3_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference XY decision for a router at (2,2): one-hot {LOCAL,S,N,W,E}.
  function automatic logic [4:0] ref_route(input int xd, input int yd);
    int dx = xd - 2;
    int dy = yd - 2;
    if (dx > 0) return 5'b00001;
    if (dx < 0) return 5'b00010;
    if (dy > 0) return 5'b00100;
    if (dy < 0) return 5'b01000;
    return 5'b10000;
  endfunction

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       Ready_out = ($urandom_range(0, 2) != 0);
      1:       Ready_out = 1'b0;
      default: Ready_out = 1'b1;
    endcase
  end

  // Monitor, scoreboard and allocator model; everything sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("ready_ip_in_reset", 64'(Ready_IP), 64'(0));
      sb_q.delete();
      occ = 0; m_rx = '0; m_tx = '0; m_lb = 1'b0; m_head = 1'b1;
      granted = 1'b0; waiting = 1'b0; route_grant = 1'b0;
      post_rst = 1'b1; prev_stall = 1'b0;
    end else begin
      if (post_rst) begin
        check("rst_outputs", 64'({route_req, Valid_out, Last_out, Data_out}), 64'(0));
        check("rst_loopback", 64'(loopback_flag), 64'(0));
        post_rst = 1'b0;
      end
      check("ready_ip", 64'(Ready_IP), 64'(occ < DEPTH));
      check("rx_cnt", 64'(rx_pkt_cnt), 64'(m_rx));
      check("tx_cnt", 64'(tx_pkt_cnt), 64'(m_tx));
      if (!Valid_out) check("idle_out_zero", 64'({Last_out, Data_out}), 64'(0));
      else            check("valid_before_grant", 64'(granted), 64'(1));
      if (prev_stall)
        check("stall_hold", 64'({Valid_out, Last_out, Data_out}), 64'({1'b1, prev_last, prev_data}));
      if (route_req != '0) begin
        check("route_req_has_pkt", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) check("route_req", 64'(route_req), 64'(sb_q[0].route));
      end
      if (Valid_IP && Ready_IP) begin
        if (m_head) m_route = ref_route(int'(Data_IP[DW-1 -: 7]), int'(Data_IP[DW-8 -: 7]));
        e.data = Data_IP; e.last = Last_IP; e.route = m_route;
        sb_q.push_back(e);
        m_head = Last_IP;
        occ++; flits_in++;
        if (Last_IP) m_rx = m_rx + 10'd1;
      end
      if (Valid_out && Ready_out) begin
        check("pop_has_expect", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("data_out", 64'(Data_out), 64'(e.data));
          check("last_out", 64'(Last_out), 64'(e.last));
          occ--; flits_out++;
          if (e.route == 5'b10000) m_lb = 1'b1;
          if (e.last) begin
            m_tx = m_tx + 10'd1;
            check("loopback_flag", 64'(loopback_flag), 64'(m_lb));
          end
        end
      end
      prev_stall = Valid_out && !Ready_out;
      prev_data  = Data_out;
      prev_last  = Last_out;
      if (route_req == '0) begin
        granted = 1'b0; waiting = 1'b0;
        route_grant = ($urandom_range(0, 3) == 0);
      end else if (!granted) begin
        if (!waiting) begin
          waiting = 1'b1;
          wait_cnt = (grant_fixed >= 0) ? grant_fixed : int'($urandom_range(0, grant_max));
        end
        if (wait_cnt == 0) begin
          route_grant = 1'b1; granted = 1'b1;
        end else begin
          route_grant = 1'b0; wait_cnt--;
        end
      end else begin
        route_grant = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic send_pkt(input int xd, input int yd, input int n, input int idle_pct);
    logic [DW-1:0] d;
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (i == 0) begin
        d[DW-1 -: 7]  = 7'(xd);
        d[DW-8 -: 7]  = 7'(yd);
        d[DW-15 -: 7] = 7'($urandom_range(0, 127));
        d[DW-22 -: 7] = 7'($urandom_range(0, 127));
      end
      while (int'($urandom_range(0, 99)) < idle_pct) begin
        Valid_IP = 1'b0;
        @(posedge clk); #1;
      end
      Valid_IP = 1'b1; Data_IP = d; Last_IP = (i == n - 1);
      t = 0;
      do begin
        acc = Ready_IP;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 3000);
      if (!acc) check("ingress_timeout", 64'(acc), 64'(1));
    end
    Valid_IP = 1'b0; Last_IP = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int t = 0;
    while ((sb_q.size() != 0 || route_req != '0) && t < maxc) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 64'(sb_q.size() == 0 && route_req == '0), 64'(1));
  endtask

  initial begin
    int t;
    int fo;
    logic [9:0] tx0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single 4-flit packet routed east.
    rdy_mode = 2;
    send_pkt(3, 2, 4, 0);
    wait_drain(200);
    check("t1_rx", 64'(rx_pkt_cnt), 64'(1));
    check("t1_tx", 64'(tx_pkt_cnt), 64'(1));
    check("t1_no_loopback", 64'(loopback_flag), 64'(0));

    // W, N, S, then a loopback packet with random ready.
    rdy_mode = 0;
    send_pkt(1, 2, $urandom_range(1, 4), 10);
    send_pkt(2, 3, $urandom_range(1, 4), 10);
    send_pkt(2, 1, $urandom_range(1, 4), 10);
    send_pkt(2, 2, $urandom_range(1, 4), 10);
    wait_drain(400);
    check("t2_loopback", 64'(loopback_flag), 64'(1));

    // Backpressure: 10 flits against a stalled crossbar.
    rdy_mode = 1; grant_fixed = 0; t3_done = 1'b0;
    fork
      begin send_pkt(5, 2, 10, 0); t3_done = 1'b1; end
    join_none
    t = 0;
    while (flits_in < 40 && t < 200) begin @(posedge clk); #1; t++; end
    fo = flits_in;
    repeat (4) @(posedge clk);
    #1;
    check("t3_ready_low", 64'(Ready_IP), 64'(0));
    check("t3_fifo_occ", 64'(occ), 64'(DEPTH));
    rdy_mode = 2;
    t = 0;
    while (!t3_done && t < 500) begin @(posedge clk); #1; t++; end
    check("t3_send_done", 64'(t3_done), 64'(1));
    wait_drain(200);

    // Back-to-back E then N packets.
    grant_fixed = -1;
    tx0 = tx_pkt_cnt;
    send_pkt(4, 2, 3, 0);
    send_pkt(2, 5, 3, 0);
    wait_drain(200);
    check("t4_tx_delta", 64'(tx_pkt_cnt - tx0), 64'(2));

    // Grant withheld for 20 cycles.
    grant_fixed = 20;
    send_pkt(2, 0, 3, 0);
    wait_drain(300);
    grant_fixed = -1;

    // Reset after two of four flits have left.
    rdy_mode = 1;
    fo = flits_out;
    send_pkt(0, 2, 4, 0);
    rdy_mode = 0;
    t = 0;
    while (flits_out - fo < 2 && t < 300) begin @(posedge clk); #1; t++; end
    check("t6_two_out", 64'(flits_out - fo >= 2), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_valid_zero", 64'(Valid_out), 64'(0));
    check("t6_req_zero", 64'(route_req), 64'(0));
    check("t6_cnt_zero", 64'({rx_pkt_cnt, tx_pkt_cnt}), 64'(0));
    send_pkt(2, 4, 2, 20);
    wait_drain(200);
    check("t6_tx_after", 64'(tx_pkt_cnt), 64'(1));

    // Counter wrap with 1030 single-flit packets.
    rdy_mode = 2; grant_fixed = 0;
    for (int i = 0; i < 1030; i++)
      send_pkt($urandom_range(0, 4), $urandom_range(0, 4), 1, 0);
    wait_drain(500);
    check("wrap_rx", 64'(rx_pkt_cnt), 64'(10'(1031)));
    check("wrap_tx", 64'(tx_pkt_cnt), 64'(10'(1031)));

    // Random mix.
    rdy_mode = 0; grant_fixed = -1; grant_max = 5;
    for (int i = 0; i < 30; i++)
      send_pkt($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(1, 5), 20);
    wait_drain(1000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
